// File: rtl/game_pkg.sv
// Shared types and constants for the dinosaur runner game controller and renderers.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2,
        OVER = 2'd3
    } game_state_t;

    localparam int unsigned GROUND_Y            = 402;
    localparam int unsigned DINO_H              = 88;
    localparam int unsigned JUMP_FRAMES_DEFAULT = 30;

    localparam int unsigned T_W      = 5;
    localparam int unsigned HEIGHT_W = 7;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned X_W      = 10;

    // Parabolic arc: (t*frames - t*t) / 2, evaluated at 12 bits then truncated.
    function automatic logic [HEIGHT_W-1:0] jump_height(input logic [T_W-1:0] t,
                                                        input int unsigned frames);
        logic [11:0] t12;
        logic [11:0] arc;
        t12 = 12'(t);
        arc = (t12 * 12'(frames)) - (t12 * t12);
        return HEIGHT_W'(arc >> 1);
    endfunction

endpackage

// File: rtl/game_ctrl_edge_sync.sv
// Two-flop synchroniser with a registered single-cycle edge pulse (rising or falling).
module edge_sync #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [2:0] sync_q;

    // sync_q[1] is the first safe sample; sync_q[2] is its previous value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], din};
            pulse  <= FALLING ? (sync_q[2] & ~sync_q[1]) : (~sync_q[2] & sync_q[1]);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Frame-level game controller: jump sequencing, game FSM, collision and score.
// Optional score counter enabled by defining GAME_CTRL_SCORE_EN.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned JUMP_FRAMES = JUMP_FRAMES_DEFAULT,
    parameter int unsigned DINO_X      = 80,
    parameter int unsigned DINO_W      = 82,
    parameter int unsigned OBST_W      = 40,
    parameter int unsigned OBST_H      = 60
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                fresh,
    input  logic                button_jump,
    input  logic [X_W-1:0]      obstacle_x,
    input  logic                obstacle_valid,
    output logic                game_status,
    output logic                jumping,
    output logic [HEIGHT_W-1:0] height,
    output logic                game_over,
    output logic [SCORE_W-1:0]  score
);

    logic tick;
    logic press;

    edge_sync #(.FALLING(1'b1)) u_fresh_sync (
        .clk   (CLK),
        .reset (RESET),
        .din   (fresh),
        .pulse (tick)
    );

    edge_sync #(.FALLING(1'b0)) u_button_sync (
        .clk   (CLK),
        .reset (RESET),
        .din   (button_jump),
        .pulse (press)
    );

    game_state_t        state_q;
    game_state_t        state_d;
    logic [T_W-1:0]     t_q;
    logic [T_W-1:0]     t_d;
    logic               height_clr;
    logic               score_inc;
    logic               score_clr;
    logic [X_W:0]       x_ext;
    logic               collide;

    // Overlap test against the registered height from before this tick.
    assign x_ext   = (X_W+1)'(obstacle_x);
    assign collide = tick && obstacle_valid
                  && (x_ext < (X_W+1)'(DINO_X + DINO_W))
                  && ((x_ext + (X_W+1)'(OBST_W)) > (X_W+1)'(DINO_X))
                  && (height < HEIGHT_W'(OBST_H));

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        height_clr = 1'b0;
        score_inc  = 1'b0;
        score_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                t_d       = '0;
                score_clr = 1'b1;
                if (press) state_d = RUN;
            end
            RUN: begin
                if (collide) begin
                    state_d = OVER;
                end else begin
                    if (press) begin
                        state_d = JUMP;
                        t_d     = '0;
                    end
                    score_inc = tick;
                end
            end
            JUMP: begin
                // Presses are ignored here: no double jump.
                if (collide) begin
                    state_d = OVER;
                end else if (tick) begin
                    score_inc = 1'b1;
                    if (t_q == T_W'(JUMP_FRAMES - 1)) begin
                        t_d     = '0;
                        state_d = RUN;
                    end else begin
                        t_d = T_W'(t_q + 1'b1);
                    end
                end
            end
            OVER: begin
                if (press) begin
                    state_d    = RUN;
                    t_d        = '0;
                    height_clr = 1'b1;
                    score_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            t_q         <= '0;
            height      <= '0;
            game_status <= 1'b0;
            jumping     <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            height      <= height_clr ? '0 : jump_height(t_q, JUMP_FRAMES);
            game_status <= (state_d == RUN) || (state_d == JUMP);
            jumping     <= (state_d == JUMP);
            game_over   <= (state_d == OVER);
        end
    end

`ifdef GAME_CTRL_SCORE_EN
    logic [SCORE_W-1:0] score_q;

    // Saturating frame counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            score_q <= '0;
        end else if (score_clr) begin
            score_q <= '0;
        end else if (score_inc && (score_q != '1)) begin
            score_q <= score_q + SCORE_W'(1);
        end
    end

    assign score = score_q;
`else
    logic unused_score;
    assign unused_score = score_inc ^ score_clr;
    assign score        = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl; score checks follow GAME_CTRL_SCORE_EN.
module tb_game_ctrl;

    logic       CLK;
    logic       RESET;
    logic       fresh;
    logic       button_jump;
    logic [9:0] obstacle_x;
    logic       obstacle_valid;
    logic       game_status;
    logic       jumping;
    logic [6:0] height;
    logic       game_over;
    logic [15:0] score;

    int n_checks = 0;
    int n_errors = 0;
    int jump_starts = 0;
    logic jumping_prev = 1'b0;
    int js0;

`ifdef GAME_CTRL_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    // Hand-computed arc t*(30-t)/2 for t = 0..30 (index 30 is the landing tick, t back to 0).
    int h_tab [31] = '{0, 14, 28, 40, 52, 62, 72, 80, 88, 94, 100, 104, 108, 110, 112, 112,
                       112, 110, 108, 104, 100, 94, 88, 80, 72, 62, 52, 40, 28, 14, 0};

    game_ctrl dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .fresh          (fresh),
        .button_jump    (button_jump),
        .obstacle_x     (obstacle_x),
        .obstacle_valid (obstacle_valid),
        .game_status    (game_status),
        .jumping        (jumping),
        .height         (height),
        .game_over      (game_over),
        .score          (score)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (jumping === 1'b1 && jumping_prev === 1'b0) jump_starts++;
        jumping_prev = jumping;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sc(input int n);
        return SCORE_ON ? n : 0;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame_tick();
        @(negedge CLK) fresh = 1'b0;
        cycles(6);
        fresh = 1'b1;
        cycles(6);
    endtask

    task automatic ticks(input int n);
        repeat (n) frame_tick();
    endtask

    task automatic press_btn();
        @(negedge CLK) button_jump = 1'b1;
        cycles(6);
        button_jump = 1'b0;
        cycles(6);
    endtask

    initial begin
        RESET          = 1'b1;
        fresh          = 1'b1;
        button_jump    = 1'b0;
        obstacle_x     = 10'd0;
        obstacle_valid = 1'b0;

        // Reset state
        cycles(2);
        check("rst_status", 32'(game_status), 0);
        check("rst_jumping", 32'(jumping), 0);
        check("rst_height", 32'(height), 0);
        check("rst_over", 32'(game_over), 0);
        check("rst_score", 32'(score), 0);
        RESET = 1'b0;
        cycles(4);

        // Start: RUN visible 4 cycles after the button rise
        button_jump = 1'b1;
        cycles(3);
        check("start_lat3", 32'(game_status), 0);
        cycles(1);
        check("start_lat4", 32'(game_status), 1);
        cycles(4);
        button_jump = 1'b0;
        cycles(6);
        check("start_jumping", 32'(jumping), 0);
        check("start_height", 32'(height), 0);

        // Full jump arc
        press_btn();
        check("arc_jump0", 32'(jumping), 1);
        check("arc_h0", 32'(height), 0);
        for (int i = 1; i <= 30; i++) begin
            frame_tick();
            check($sformatf("arc_h%0d", i), 32'(height), 32'(h_tab[i]));
            check($sformatf("arc_j%0d", i), 32'(jumping), (i < 30) ? 1 : 0);
        end
        check("arc_status", 32'(game_status), 1);
        check("arc_score", 32'(score), 32'(exp_sc(30)));

        // Held button: one jump only
        js0 = jump_starts;
        @(negedge CLK) button_jump = 1'b1;
        ticks(100);
        check("hold_jumps", 32'(jump_starts - js0), 1);
        check("hold_jumping", 32'(jumping), 0);
        check("hold_status", 32'(game_status), 1);
        button_jump = 1'b0;
        cycles(6);
        check("hold_score", 32'(score), 32'(exp_sc(130)));

        // Collision window boundaries on the ground
        obstacle_valid = 1'b1;
        obstacle_x = 10'd40;
        frame_tick();
        check("x40_no_hit", 32'(game_over), 0);
        obstacle_x = 10'd162;
        frame_tick();
        check("x162_no_hit", 32'(game_over), 0);
        obstacle_valid = 1'b0;
        obstacle_x = 10'd100;
        frame_tick();
        check("invalid_no_hit", 32'(game_over), 0);
        obstacle_valid = 1'b1;
        obstacle_x = 10'd161;
        frame_tick();
        check("x161_over", 32'(game_over), 1);
        check("x161_status", 32'(game_status), 0);
        check("x161_score", 32'(score), 32'(exp_sc(133)));
        frame_tick();
        check("over_hold", 32'(game_over), 1);
        check("over_score_frz", 32'(score), 32'(exp_sc(133)));

        // Restart from OVER, then left edge hit at x = 41
        obstacle_valid = 1'b0;
        press_btn();
        check("restart_status", 32'(game_status), 1);
        check("restart_over", 32'(game_over), 0);
        check("restart_score", 32'(score), 0);
        obstacle_valid = 1'b1;
        obstacle_x = 10'd41;
        frame_tick();
        check("x41_over", 32'(game_over), 1);
        obstacle_valid = 1'b0;
        obstacle_x = 10'd100;
        press_btn();
        check("restart2_status", 32'(game_status), 1);

        // Dino high enough (62 >= 60): obstacle passes underneath
        press_btn();
        ticks(5);
        check("high_h5", 32'(height), 62);
        obstacle_valid = 1'b1;
        frame_tick();
        check("high_no_hit", 32'(game_over), 0);
        check("high_jumping", 32'(jumping), 1);
        check("high_h6", 32'(height), 72);
        obstacle_valid = 1'b0;
        ticks(24);
        check("high_land", 32'(jumping), 0);
        check("high_score", 32'(score), 32'(exp_sc(30)));

        // Collision on the final jump tick wins over landing
        press_btn();
        ticks(29);
        check("last_jumping", 32'(jumping), 1);
        check("last_h29", 32'(height), 14);
        obstacle_valid = 1'b1;
        frame_tick();
        check("last_over", 32'(game_over), 1);
        check("last_not_run", 32'(game_status), 0);
        check("last_h_frz", 32'(height), 14);
        check("last_score", 32'(score), 32'(exp_sc(59)));
        obstacle_valid = 1'b0;
        press_btn();
        check("last_restart", 32'(game_status), 1);
        check("last_h_clr", 32'(height), 0);
        check("last_score_clr", 32'(score), 0);

        // Second press mid-jump is ignored
        press_btn();
        ticks(10);
        press_btn();
        ticks(19);
        check("dbl_jumping29", 32'(jumping), 1);
        check("dbl_h29", 32'(height), 14);
        frame_tick();
        check("dbl_land", 32'(jumping), 0);
        check("dbl_status", 32'(game_status), 1);

        // Reset in the middle of a jump
        press_btn();
        ticks(3);
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK);
        check("mid_rst_status", 32'(game_status), 0);
        check("mid_rst_jumping", 32'(jumping), 0);
        check("mid_rst_height", 32'(height), 0);
        check("mid_rst_over", 32'(game_over), 0);
        check("mid_rst_score", 32'(score), 0);
        RESET = 1'b0;
        cycles(4);
        frame_tick();
        check("idle_tick_status", 32'(game_status), 0);
        check("idle_tick_score", 32'(score), 0);

`ifdef GAME_CTRL_SCORE_EN
        // Long run, freeze on collision, clear on restart, then saturation
        press_btn();
        ticks(500);
        check("sc_500", 32'(score), 500);
        obstacle_valid = 1'b1;
        frame_tick();
        check("sc_over", 32'(game_over), 1);
        check("sc_frozen", 32'(score), 500);
        obstacle_valid = 1'b0;
        press_btn();
        check("sc_clr", 32'(score), 0);
        @(negedge CLK);
        force dut.score_q = 16'hFFFE;
        #1 release dut.score_q;
        ticks(3);
        check("sc_sat", 32'(score), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
